mont_mul_arbiter: RTL and testbench

MONT_MUL_ARBITER -- requirements
Module: mont_mul_arbiter

---
 rtl/mont_pkg.sv | 25 ++
 rtl/REDC3329_pipeline.sv | 51 +++++
 rtl/mont_rsp_fifo.sv | 45 ++++
 rtl/mont_mul_arbiter.sv | 123 ++++++++++++
 tb/tb_mont_mul_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mont_pkg.sv
// Shared constants and types for the modular-multiplier arbiter.
// Arithmetic is modulo Q=3329 on 12-bit residues.
package mont_pkg;
  localparam int Q       = 3329;
  localparam int WIDTH   = 12;
  localparam int MUL_LAT = 4;
  // Widest requester id a result entry can carry
  localparam int ID_W    = 4;

  // Barrett constant: floor(2^24 / Q); a 24-bit product needs at most one correction
  localparam int BARRETT_K = 24;
  localparam int BARRETT_M = (1 << BARRETT_K) / Q;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] r;
  } rsp_entry_t;

  function automatic logic [WIDTH-1:0] cond_sub_q(input logic [WIDTH:0] x);
    logic [WIDTH:0] qx;
    qx = (WIDTH+1)'(Q);
    if (x >= qx) return WIDTH'(x - qx);
    return WIDTH'(x);
  endfunction
endpackage

// File: rtl/REDC3329_pipeline.sv
// Pipelined a*b mod 3329 (Barrett reduction); done/r appear LAT edges after en.
// LAT must be at least four: multiply, quotient, remainder, correction.
module REDC3329_pipeline
  import mont_pkg::*;
#(
  parameter int LAT = MUL_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] r
);
  localparam int SW = 2*WIDTH + 13;
  localparam logic [2*WIDTH-1:0] Q_W = (2*WIDTH)'(Q);

  logic [LAT:1]       vld_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [2*WIDTH-1:0] prod2_reg;
  logic [WIDTH-1:0]   quot_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   res_reg [4:LAT];
  logic [SW-1:0]      scaled;

  assign scaled = SW'(prod_reg) * SW'(BARRETT_M);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
    end else begin
      vld_reg <= {vld_reg[LAT-1:1], en};
    end
  end

  always_ff @(posedge clk) begin
    prod_reg  <= (2*WIDTH)'(a) * (2*WIDTH)'(b);
    prod2_reg <= prod_reg;
    quot_reg  <= WIDTH'(scaled >> BARRETT_K);
    // Estimated quotient is low by at most one, so the remainder is below 2Q
    rem_reg   <= (WIDTH+1)'(prod2_reg - {{WIDTH{1'b0}}, quot_reg} * Q_W);
    res_reg[4] <= cond_sub_q(rem_reg);
    for (int i = 5; i <= LAT; i++) begin
      res_reg[i] <= res_reg[i-1];
    end
  end

  assign done = vld_reg[LAT];
  assign r    = res_reg[LAT];
endmodule

// File: rtl/mont_rsp_fifo.sv
// Show-ahead result FIFO; head reads as zero while empty. Caller never pushes when full.
module mont_rsp_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [15:0]
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_pop;

  assign empty  = (count_reg == '0);
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !do_pop)      count_reg <= count_reg + (AW+1)'(1);
      else if (!push && do_pop) count_reg <= count_reg - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = empty ? '0 : mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/mont_mul_arbiter.sv
// Round-robin arbiter feeding one shared mod-3329 multiplier; results return
// through a credit-protected FIFO in global issue order, tagged with requester id.
module mont_mul_arbiter
  import mont_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LAT        = MUL_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_r,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [IDW-1:0]   last_grant_reg;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  int               sel_idx;
  logic             credit_ok;
  logic             transfer;
  logic [CW-1:0]    inflight_reg;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [LAT:1]     tag_vld_reg;
  logic [IDW-1:0]   tag_reg [1:LAT];
  logic             mul_done;
  logic [WIDTH-1:0] mul_r;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             push;
  rsp_entry_t       push_entry;
  rsp_entry_t       head;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sel_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel_idx = int'(last_grant_reg) + k;
      if (sel_idx >= NUM_REQ) sel_idx = sel_idx - NUM_REQ;
      if (!grant_any && req_valid[sel_idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(sel_idx);
      end
    end
  end

  // Credit uses registered occupancy only, so a pop this cycle frees a slot next cycle
  assign credit_ok = rst_n &&
                     ((CW+1)'(fifo_count) + (CW+1)'(inflight_reg) < (CW+1)'(FIFO_DEPTH));
  assign transfer  = grant_any && credit_ok;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = transfer && (int'(grant_id) == gi);
  end

  assign a_sel = req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(grant_id)*WIDTH +: WIDTH];

  REDC3329_pipeline #(
    .LAT (LAT)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (transfer),
    .a     (a_sel),
    .b     (b_sel),
    .done  (mul_done),
    .r     (mul_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= IDW'(NUM_REQ - 1);
      inflight_reg   <= '0;
      tag_vld_reg    <= '0;
      for (int i = 1; i <= LAT; i++) tag_reg[i] <= '0;
    end else begin
      if (transfer) last_grant_reg <= grant_id;
      case ({transfer, push})
        2'b10:   inflight_reg <= inflight_reg + CW'(1);
        2'b01:   inflight_reg <= inflight_reg - CW'(1);
        default: inflight_reg <= inflight_reg;
      endcase
      tag_vld_reg <= {tag_vld_reg[LAT-1:1], transfer};
      tag_reg[1]  <= grant_id;
      for (int i = 2; i <= LAT; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  assign push          = mul_done && tag_vld_reg[LAT];
  assign push_entry.id = ID_W'(tag_reg[LAT]);
  assign push_entry.r  = mul_r;

  mont_rsp_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rsp_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (rsp_valid && rsp_ready),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_id    = IDW'(head.id);
  assign rsp_r     = head.r;
  assign busy      = (inflight_reg != '0) || !fifo_empty;
endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Randomised scoreboard bench: a request-level model predicts grants and results,
// a monitor pops and compares whatever the DUT presents on rsp_*.
`timescale 1ns/1ps
module tb_mont_mul_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int LAT        = 4;
  localparam int QM         = 3329;
  localparam int W          = 12;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*W-1:0]     req_a;
  logic [NUM_REQ*W-1:0]     req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic [W-1:0]             rsp_r;
  logic                     busy;

  mont_mul_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LAT        (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int r;
    int vis;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   issued = 0;
  int   popped = 0;
  int   last_g = NUM_REQ - 1;
  int   dut_xfers = 0;
  int   mode = 0;
  bit   pv [NUM_REQ];
  int   pa [NUM_REQ];
  int   pb [NUM_REQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic new_op(input int i);
    pa[i] = $urandom_range(0, QM-1);
    pb[i] = $urandom_range(0, QM-1);
  endtask

  task automatic model_reset();
    sb.delete();
    issued = 0;
    popped = 0;
    last_g = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
  endtask

  // One clock: apply requester state, check at negedge, update the model.
  task automatic step();
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    int idx;
    int outstanding;
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = pv[i];
      req_a[i*W +: W]     = W'(pa[i]);
      req_b[i*W +: W]     = W'(pb[i]);
    end
    @(negedge clk);
    outstanding = issued - popped;
    exp_ready = '0;
    g = -1;
    if (rst_n && outstanding < FIFO_DEPTH) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (last_g + k) % NUM_REQ;
        if (g < 0 && pv[idx]) g = idx;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(outstanding > 0));
    if (!rst_n) begin
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_r", 32'(rsp_r), 0);
    end
    if ((req_ready & req_valid) != '0) dut_xfers++;
    if (g >= 0) begin
      e.id  = g;
      e.r   = (pa[g] * pb[g]) % QM;
      e.vis = cyc + LAT + 1;
      sb.push_back(e);
      issued++;
      last_g = g;
      case (mode)
        0: pv[g] = 1'b0;
        1: begin pv[g] = 1'b1; new_op(g); end
        default: begin pv[g] = ($urandom_range(0, 2) != 0); new_op(g); end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: runs just after the stimulus checks in each cycle.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        exp_v = (sb.size() > 0) && (sb[0].vis <= cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 0);
          end else begin
            check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            check("rsp_r", 32'(rsp_r), 32'(sb[0].r));
            $display("cycle %0d rsp id=%0d r=%0d (want id=%0d r=%0d)",
                     cyc, rsp_id, rsp_r, sb[0].id, sb[0].r);
            void'(sb.pop_front());
            popped++;
          end
        end
      end
    end
  end

  task automatic send(input int id, input int a, input int b);
    pa[id] = a;
    pb[id] = b;
    pv[id] = 1'b1;
    mode   = 0;
    for (int n = 0; n < 20 && pv[id]; n++) step();
    if (pv[id]) check("send_timeout", 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 200 && (sb.size() > 0 || issued != popped); n++) step();
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 0);
    step();
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin pa[i] = 0; pb[i] = 0; end
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Single op, then boundary operands, on different requesters
    send(0, 17, 19);
    drain();
    send(1, 3328, 3328);
    send(1, 0, 2500);
    send(2, 1234, 2);
    drain();

    // All requesters continuously valid: rotating grants
    mode = 1;
    for (int i = 0; i < NUM_REQ; i++) begin pv[i] = 1'b1; new_op(i); end
    repeat (8) step();
    drain();

    // Back-pressure: exactly FIFO_DEPTH transfers, then resume
    rsp_ready = 1'b0;
    mode = 1;
    for (int i = 0; i < NUM_REQ; i++) begin pv[i] = 1'b1; new_op(i); end
    dut_xfers = 0;
    repeat (20) step();
    check("stall_xfers", 32'(dut_xfers), FIFO_DEPTH);
    rsp_ready = 1'b1;
    repeat (30) step();
    drain();

    // Reset pulse with work in flight
    rsp_ready = 1'b0;
    mode = 1;
    pv[0] = 1'b1;
    new_op(0);
    repeat (3) step();
    pv[0] = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) step();
    send(0, 5, 7);
    drain();

    // Random traffic
    mode = 2;
    for (int n = 0; n < 40000 && issued < 10000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin pv[i] = 1'b1; new_op(i); end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
